huff_byte_serializer: RTL and testbench



---
 rtl/huff_byte_serializer_pkg.sv | 17 +
 rtl/huff_byte_serializer_tail_mask.sv | 15 +
 rtl/huff_byte_serializer.sv | 166 ++++++++++++++++
 tb/tb_huff_byte_serializer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/huff_byte_serializer_pkg.sv
// Shared constants and state encoding for the Huffman byte serializer.
// Optional header bytes are enabled by defining HUFF_SER_HDR_EN.
package huff_byte_serializer_pkg;

   localparam int HUFF_BUF_W     = 1024;
   localparam int HUFF_CNT_W     = 11;
   localparam int HUFF_BYTE_W    = 8;
   localparam int HUFF_MAX_BYTES = 128;

   typedef enum logic [1:0] {
      SER_IDLE = 2'd0,
      SER_HDR0 = 2'd1,
      SER_HDR1 = 2'd2,
      SER_SEND = 2'd3
   } ser_state_t;

endpackage

// File: rtl/huff_byte_serializer_tail_mask.sv
// Keep mask for a packed stream: the top cnt bits are 1, everything below is 0.
// cnt must already be saturated to BUF_W.
module huff_byte_serializer_tail_mask
   import huff_byte_serializer_pkg::*;
#(
   parameter int BUF_W = HUFF_BUF_W,
   parameter int CNT_W = HUFF_CNT_W
) (
   input  logic [CNT_W-1:0] cnt,
   output logic [BUF_W-1:0] keep
);

   assign keep = ~({BUF_W{1'b1}} >> cnt);

endmodule

// File: rtl/huff_byte_serializer.sv
// Captures a packed Huffman stream and emits it MSB-first as bytes over valid/ready.
// Define HUFF_SER_HDR_EN to prefix each stream with a two-byte bit-count header.
module huff_byte_serializer
   import huff_byte_serializer_pkg::*;
#(
   parameter int BUF_W  = HUFF_BUF_W,
   parameter int CNT_W  = HUFF_CNT_W,
   parameter int BYTE_W = HUFF_BYTE_W
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [BUF_W-1:0]  in_data,
   input  logic [CNT_W-1:0]  in_count,
   output logic [BYTE_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic              busy,
   output logic              done
);

   localparam int NB_W = $clog2(HUFF_MAX_BYTES + 1);
   localparam int SH   = $clog2(BYTE_W);

   function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] c);
      if (c > CNT_W'(BUF_W)) return CNT_W'(BUF_W);
      return c;
   endfunction

   function automatic logic [NB_W-1:0] byte_count(input logic [CNT_W-1:0] c);
      logic [CNT_W:0] t;
      t = {1'b0, c} + (CNT_W+1)'(BYTE_W - 1);
      return NB_W'(t >> SH);
   endfunction

   ser_state_t        state;
   logic [BUF_W-1:0]  shreg;
   logic [NB_W-1:0]   nbytes;
   logic [CNT_W-1:0]  cap_cnt;
   logic [NB_W-1:0]   cap_nbytes;
   logic [BUF_W-1:0]  keep;
   logic              capture;
   logic              accept;
`ifdef HUFF_SER_HDR_EN
   logic [CNT_W-1:0]  cnt_r;
`endif

   assign in_ready   = (state == SER_IDLE) & ~RST;
   assign capture    = in_valid & in_ready;
   assign accept     = m_valid & m_ready;
   assign cap_cnt    = sat_count(in_count);
   assign cap_nbytes = byte_count(cap_cnt);

   huff_byte_serializer_tail_mask #(
      .BUF_W (BUF_W),
      .CNT_W (CNT_W)
   ) u_tail_mask (
      .cnt  (cap_cnt),
      .keep (keep)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= SER_IDLE;
         nbytes  <= '0;
         m_valid <= 1'b0;
         m_last  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            SER_IDLE: begin
               if (capture) begin
                  nbytes <= cap_nbytes;
`ifdef HUFF_SER_HDR_EN
                  state   <= SER_HDR0;
                  m_valid <= 1'b1;
                  m_last  <= 1'b0;
                  busy    <= 1'b1;
`else
                  // An empty stream has nothing to send: finish immediately.
                  if (cap_nbytes == '0) begin
                     done <= 1'b1;
                  end else begin
                     state   <= SER_SEND;
                     m_valid <= 1'b1;
                     m_last  <= (cap_nbytes == NB_W'(1));
                     busy    <= 1'b1;
                  end
`endif
               end
            end
`ifdef HUFF_SER_HDR_EN
            SER_HDR0: begin
               if (accept) begin
                  state  <= SER_HDR1;
                  m_last <= (nbytes == '0);
               end
            end
            SER_HDR1: begin
               if (accept) begin
                  if (nbytes == '0) begin
                     state   <= SER_IDLE;
                     m_valid <= 1'b0;
                     m_last  <= 1'b0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     state  <= SER_SEND;
                     m_last <= (nbytes == NB_W'(1));
                  end
               end
            end
`endif
            SER_SEND: begin
               if (accept) begin
                  nbytes <= nbytes - NB_W'(1);
                  if (nbytes == NB_W'(1)) begin
                     state   <= SER_IDLE;
                     m_valid <= 1'b0;
                     m_last  <= 1'b0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     m_last <= (nbytes == NB_W'(2));
                  end
               end
            end
            default: begin
               state   <= SER_IDLE;
               m_valid <= 1'b0;
               m_last  <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

   // Payload shifter carries no reset; it is only observed while in SER_SEND.
   always_ff @(posedge CLK) begin
      if (capture) begin
         shreg <= in_data & keep;
`ifdef HUFF_SER_HDR_EN
         cnt_r <= cap_cnt;
`endif
      end else if (accept && (state == SER_SEND)) begin
         shreg <= shreg << BYTE_W;
      end
   end

   always_comb begin
      m_data = '0;
      case (state)
`ifdef HUFF_SER_HDR_EN
         SER_HDR0: m_data = BYTE_W'(cnt_r >> BYTE_W);
         SER_HDR1: m_data = cnt_r[BYTE_W-1:0];
`endif
         SER_SEND: m_data = shreg[BUF_W-1 -: BYTE_W];
         default:  m_data = '0;
      endcase
   end

endmodule

// File: tb/tb_huff_byte_serializer.sv
// Self-checking bench for huff_byte_serializer; honours HUFF_SER_HDR_EN when defined.
module tb_huff_byte_serializer;

`ifdef HUFF_SER_HDR_EN
   localparam int HOFF = 2;
`else
   localparam int HOFF = 0;
`endif

   logic          CLK = 1'b0;
   logic          RST;
   logic          in_valid;
   logic          in_ready;
   logic [1023:0] in_data;
   logic [10:0]   in_count;
   logic [7:0]    m_data;
   logic          m_valid;
   logic          m_ready;
   logic          m_last;
   logic          busy;
   logic          done;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] exp_q[$];
   bit         exp_last_q[$];
   logic [7:0] got_q[$];
   bit         got_last_q[$];

   int hold_err, busy_err, rdy_err, stalled;
   int done_cyc, first_vld_cyc, last_acc_cyc;
   bit timeout, done_pulse_ok, rdy_after_done;

   always #5 CLK = ~CLK;

   huff_byte_serializer dut (
      .CLK      (CLK),
      .RST      (RST),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_count (in_count),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_last   (m_last),
      .busy     (busy),
      .done     (done)
   );

   // Expected byte stream straight from the bit-level description of the format.
   function automatic void model(input int cnt_in, input logic [1023:0] d);
      int cnt;
      int nb;
      logic [7:0] b;
      exp_q.delete();
      exp_last_q.delete();
      cnt = (cnt_in > 1024) ? 1024 : cnt_in;
      nb  = (cnt + 7) / 8;
`ifdef HUFF_SER_HDR_EN
      exp_q.push_back(8'(cnt / 256));
      exp_q.push_back(8'(cnt % 256));
`endif
      for (int k = 0; k < nb; k++) begin
         b = 8'h00;
         for (int j = 0; j < 8; j++)
            if (8 * k + j < cnt) b[7-j] = d[1023 - (8 * k + j)];
         exp_q.push_back(b);
      end
      for (int i = 0; i < exp_q.size(); i++) exp_last_q.push_back(i == exp_q.size() - 1);
   endfunction

   function automatic int first_diff();
      int n;
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         if (got_q[i] !== exp_q[i] || got_last_q[i] !== exp_last_q[i]) return i;
      return -1;
   endfunction

   function automatic logic [1023:0] rand_data();
      logic [1023:0] d;
      for (int i = 0; i < 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   task automatic start_stream(input int cnt, input logic [1023:0] d);
      @(negedge CLK);
      in_valid = 1'b1;
      in_data  = d;
      in_count = 11'(cnt);
      model(cnt, d);
   endtask

   task automatic collect(input int ready_pct, input int stall_len, input bit inject,
                          input int stop_after);
      int cyc = 0;
      int nacc = 0;
      int stall_left = stall_len;
      bit prev_stall = 1'b0;
      bit r;
      logic [7:0] pd = 8'h00;
      logic pl = 1'b0;
      got_q.delete();
      got_last_q.delete();
      hold_err = 0; busy_err = 0; rdy_err = 0; stalled = 0;
      done_cyc = -1; first_vld_cyc = -1; last_acc_cyc = -1;
      timeout = 1'b0; done_pulse_ok = 1'b0; rdy_after_done = 1'b0;
      forever begin
         @(negedge CLK);
         in_valid = inject;
         if (inject) begin
            in_data  = rand_data();
            in_count = 11'($urandom);
         end
         if (done) begin
            in_valid = 1'b0;
            m_ready  = 1'b0;
            done_cyc = cyc;
            rdy_after_done = in_ready;
            if (m_valid || busy) busy_err++;
            @(negedge CLK);
            done_pulse_ok = !done;
            break;
         end
         if (in_ready) rdy_err++;
         if (m_valid) begin
            if (first_vld_cyc < 0) first_vld_cyc = cyc;
            if (!busy) busy_err++;
            if (prev_stall && (m_data !== pd || m_last !== pl)) hold_err++;
         end else if (busy) begin
            busy_err++;
         end
         if (nacc == 0 && stall_left > 0 && m_valid) begin
            r = 1'b0;
            stall_left--;
            stalled++;
         end else begin
            r = ($urandom_range(99) < ready_pct);
         end
         m_ready = r;
         if (m_valid && r) begin
            got_q.push_back(m_data);
            got_last_q.push_back(m_last);
            nacc++;
            last_acc_cyc = cyc;
         end
         prev_stall = m_valid && !r;
         pd = m_data;
         pl = m_last;
         cyc++;
         if (stop_after > 0 && nacc == stop_after) break;
         if (cyc > 3000) begin
            timeout = 1'b1;
            in_valid = 1'b0;
            m_ready = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      RST = 1'b1; in_valid = 1'b0; m_ready = 1'b0; in_data = '0; in_count = '0;
      repeat (3) @(negedge CLK);
      n_checks++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid got %b want 0", m_valid); else n_pass++;
      n_checks++; if (m_last !== 1'b0) $display("FAIL reset_m_last got %b want 0", m_last); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
      n_checks++; if (m_data !== 8'h00) $display("FAIL reset_m_data got %h want 00", m_data); else n_pass++;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else n_pass++;
      RST = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready got %b want 1", in_ready); else n_pass++;
   endtask

   task automatic test_basic();
      logic [1023:0] d = '1;
      d[1023:1008] = 16'hA55A;
      start_stream(16, d);
      collect(100, 0, 1'b0, 0);
      n_checks++; if (timeout !== 1'b0) $display("FAIL basic_timeout got %b want 0", timeout); else n_pass++;
      n_checks++; if (got_q.size() !== exp_q.size()) $display("FAIL basic_len got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
      n_checks++; if (first_diff() !== -1) $display("FAIL basic_stream first bad index %0d", first_diff()); else n_pass++;
      n_checks++; if (got_q.size() == HOFF + 2 && {got_q[HOFF], got_q[HOFF+1]} !== 16'hA55A)
         $display("FAIL basic_bytes got %h%h want a55a", got_q[HOFF], got_q[HOFF+1]); else n_pass++;
      n_checks++; if (first_vld_cyc !== 0) $display("FAIL basic_latency got %0d want 0", first_vld_cyc); else n_pass++;
      n_checks++; if (done_cyc !== last_acc_cyc + 1) $display("FAIL basic_done_time got %0d want %0d", done_cyc, last_acc_cyc + 1); else n_pass++;
      n_checks++; if (done_pulse_ok !== 1'b1) $display("FAIL basic_done_width got %b want 1", done_pulse_ok); else n_pass++;
      n_checks++; if (busy_err !== 0) $display("FAIL basic_busy got %0d errors want 0", busy_err); else n_pass++;
   endtask

   task automatic test_padding();
      logic [1023:0] d = '1;
      d[1023:1011] = 13'h1ABC;
      start_stream(13, d);
      collect(100, 0, 1'b0, 0);
      n_checks++; if (got_q.size() !== exp_q.size()) $display("FAIL pad_len got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
      n_checks++; if (first_diff() !== -1) $display("FAIL pad_stream first bad index %0d", first_diff()); else n_pass++;
      n_checks++; if (got_q.size() == HOFF + 2 && {got_q[HOFF], got_q[HOFF+1], got_last_q[HOFF+1]} !== {16'hD5E0, 1'b1})
         $display("FAIL pad_bytes got %h%h last %b want d5e0 last 1", got_q[HOFF], got_q[HOFF+1], got_last_q[HOFF+1]); else n_pass++;
   endtask

   task automatic test_backpressure();
      logic [1023:0] d = '1;
      d[1023:1008] = 16'hA55A;
      start_stream(16, d);
      collect(100, 5, 1'b0, 0);
      n_checks++; if (stalled !== 5) $display("FAIL bp_stall_cycles got %0d want 5", stalled); else n_pass++;
      n_checks++; if (hold_err !== 0) $display("FAIL bp_hold got %0d unstable cycles want 0", hold_err); else n_pass++;
      n_checks++; if (got_q.size() !== exp_q.size()) $display("FAIL bp_len got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
      n_checks++; if (first_diff() !== -1) $display("FAIL bp_stream first bad index %0d", first_diff()); else n_pass++;
   endtask

   task automatic test_zero();
      start_stream(0, '1);
      collect(100, 0, 1'b0, 0);
      n_checks++; if (timeout !== 1'b0) $display("FAIL zero_timeout got %b want 0", timeout); else n_pass++;
      n_checks++; if (done_pulse_ok !== 1'b1) $display("FAIL zero_done_width got %b want 1", done_pulse_ok); else n_pass++;
      n_checks++; if (rdy_after_done !== 1'b1) $display("FAIL zero_in_ready got %b want 1", rdy_after_done); else n_pass++;
`ifdef HUFF_SER_HDR_EN
      n_checks++; if (got_q.size() !== 2) $display("FAIL zero_len got %0d want 2", got_q.size()); else n_pass++;
      n_checks++; if (got_q.size() == 2 && {got_q[0], got_q[1], got_last_q[0], got_last_q[1]} !== {16'h0000, 2'b01})
         $display("FAIL zero_hdr got %h%h last %b%b want 0000 last 01", got_q[0], got_q[1], got_last_q[0], got_last_q[1]); else n_pass++;
      n_checks++; if (done_cyc !== last_acc_cyc + 1) $display("FAIL zero_done_time got %0d want %0d", done_cyc, last_acc_cyc + 1); else n_pass++;
`else
      n_checks++; if (first_vld_cyc !== -1) $display("FAIL zero_m_valid seen at cycle %0d want never", first_vld_cyc); else n_pass++;
      n_checks++; if (done_cyc !== 0) $display("FAIL zero_done_time got %0d want 0", done_cyc); else n_pass++;
`endif
   endtask

   task automatic test_full_ignore();
      logic [1023:0] d;
      for (int k = 0; k < 128; k++) d[1023 - 8*k -: 8] = 8'(k);
      start_stream(1024, d);
      collect(100, 0, 1'b1, 0);
      n_checks++; if (got_q.size() !== HOFF + 128) $display("FAIL full_len got %0d want %0d", got_q.size(), HOFF + 128); else n_pass++;
      n_checks++; if (first_diff() !== -1) $display("FAIL full_stream first bad index %0d", first_diff()); else n_pass++;
      n_checks++; if (got_q.size() == HOFF + 128 && got_q[HOFF + 127] !== 8'h7F)
         $display("FAIL full_last_byte got %h want 7f", got_q[HOFF + 127]); else n_pass++;
      n_checks++; if (rdy_err !== 0) $display("FAIL full_in_ready_busy got %0d cycles want 0", rdy_err); else n_pass++;
      n_checks++; if (busy_err !== 0) $display("FAIL full_busy got %0d errors want 0", busy_err); else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [1023:0] d;
      for (int k = 0; k < 128; k++) d[1023 - 8*k -: 8] = 8'(k);
      start_stream(1024, d);
      collect(100, 0, 1'b0, 3);
      n_checks++; if (got_q.size() !== 3 || first_diff() !== -1) $display("FAIL rstmid_prefix got %0d bytes bad index %0d", got_q.size(), first_diff()); else n_pass++;
      @(negedge CLK);
      RST = 1'b1;
      m_ready = 1'b0;
      @(negedge CLK);
      n_checks++; if (m_valid !== 1'b0) $display("FAIL rstmid_m_valid got %b want 0", m_valid); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else n_pass++;
      n_checks++; if (m_data !== 8'h00) $display("FAIL rstmid_m_data got %h want 00", m_data); else n_pass++;
      RST = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready got %b want 1", in_ready); else n_pass++;
   endtask

   task automatic test_random();
      int cnt;
      int sel;
      for (int it = 0; it < 10; it++) begin
         sel = $urandom_range(9);
         if (sel == 0)      cnt = 0;
         else if (sel == 1) cnt = 1025 + $urandom_range(1022);
         else               cnt = $urandom_range(1024, 1);
         start_stream(cnt, rand_data());
         collect(50, $urandom_range(3), 1'($urandom_range(1)), 0);
         n_checks++; if (timeout !== 1'b0) $display("FAIL rand%0d_timeout cnt %0d", it, cnt); else n_pass++;
         n_checks++; if (got_q.size() !== exp_q.size()) $display("FAIL rand%0d_len cnt %0d got %0d want %0d", it, cnt, got_q.size(), exp_q.size()); else n_pass++;
         n_checks++; if (first_diff() !== -1) $display("FAIL rand%0d_stream cnt %0d first bad index %0d", it, cnt, first_diff()); else n_pass++;
         n_checks++; if (hold_err + rdy_err + busy_err !== 0)
            $display("FAIL rand%0d_ctrl hold %0d ready %0d busy %0d want 0", it, hold_err, rdy_err, busy_err); else n_pass++;
         n_checks++; if (done_cyc !== ((exp_q.size() == 0) ? 0 : last_acc_cyc + 1))
            $display("FAIL rand%0d_done_time got %0d last accept %0d", it, done_cyc, last_acc_cyc); else n_pass++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_padding();
      test_backpressure();
      test_zero();
      test_full_ignore();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
